// File: rtl/ifu_pkg.sv
// Shared constants and payload types for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned ILEN      = 32;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned OCC_W     = CNT_W + 1;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0000_0013;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_queue.sv
// Two-entry instruction queue; the head lives in registers that drive decode directly.
module ifu_queue
  import ifu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  fetch_entry_t       push_entry,
  output logic               head_valid,
  output fetch_entry_t       head,
  output logic [XLEN-1:0]    head_snxt_pc,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t tail_q;

  // Head/tail shift structure; snxt is computed whenever the head is reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      head_valid   <= 1'b0;
      head         <= '0;
      head_snxt_pc <= '0;
      tail_q       <= '0;
    end else if (clear) begin
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == '0) begin
            head         <= push_entry;
            head_snxt_pc <= push_entry.pc + 64'd4;
          end else begin
            tail_q <= push_entry;
          end
          count      <= count + CNT_W'(1);
          head_valid <= 1'b1;
        end
        2'b01: begin
          head         <= tail_q;
          head_snxt_pc <= tail_q.pc + 64'd4;
          count        <= count - CNT_W'(1);
          head_valid   <= (count == CNT_W'(2));
        end
        2'b11: begin
          if (count == CNT_W'(1)) begin
            head         <= push_entry;
            head_snxt_pc <= push_entry.pc + 64'd4;
          end else begin
            head         <= tail_q;
            head_snxt_pc <= tail_q.pc + 64'd4;
            tail_q       <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches and feeds decode
// from a 2-entry queue, discarding stale responses after a redirect.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             redirect_en,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             halt,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [ILEN-1:0]  imem_resp_data,
  output logic             ifu_valid,
  output logic [ILEN-1:0]  ifu_instr,
  output logic [XLEN-1:0]  ifu_pc,
  output logic [XLEN-1:0]  ifu_snxt_pc
);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  resp_pc;
  logic [XLEN-1:0]  redirect_tgt;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] occupancy;
  logic             head_valid;
  logic             pop;
  logic             push;
  logic             resp_drop;
  logic             req_fire;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  assign redirect_tgt = redirect_pc & ~64'd3;

  assign pop       = head_valid & ~hazard_stall & ~redirect_en;
  assign resp_drop = imem_resp_valid & (drop_cnt != '0);
  assign push      = imem_resp_valid & (drop_cnt == '0) & ~redirect_en;

  // A head leaving this cycle frees its slot, which keeps 1 instr/cycle with 1-cycle memory.
  assign occupancy      = OCC_W'(inflight) + OCC_W'(count) - OCC_W'(pop);
  assign imem_req_valid = ~rst & (state == ST_RUN) & ~redirect_en
                          & (occupancy < OCC_W'(BUF_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses return in order, so the next kept response always belongs to resp_pc.
  assign push_entry = '{pc: resp_pc, instr: imem_resp_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (halt) state_nxt = ST_HALT;
      ST_HALT: if (redirect_en || !halt) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // PC, outstanding-request and drop bookkeeping; redirect overrides everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
      if (redirect_en) begin
        pc       <= redirect_tgt;
        resp_pc  <= redirect_tgt;
        drop_cnt <= inflight - CNT_W'(imem_resp_valid);
      end else begin
        if (req_fire)  pc       <= pc + 64'd4;
        if (push)      resp_pc  <= resp_pc + 64'd4;
        if (resp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  ifu_queue u_queue (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .clear        (redirect_en),
    .push_entry   (push_entry),
    .head_valid   (head_valid),
    .head         (head),
    .head_snxt_pc (ifu_snxt_pc),
    .count        (count)
  );

  assign ifu_valid = head_valid;
  assign ifu_instr = head.instr;
  assign ifu_pc    = head.pc;

  a_occupancy: assert property (@(posedge clk) disable iff (rst)
    (OCC_W'(inflight) + OCC_W'(count)) <= OCC_W'(BUF_DEPTH));

endmodule
